controle_catracas_multi: RTL and testbench
==========================================

Name: controle_catracas_multi

Overview:
- Parametrised multi-lane turnstile/security-gate controller; next generation of the single-gate FSM.
- Runs LANES independent gate FSMs, each with entry/exit/metal-detector inputs.
- Keeps a shared, capacity-limited occupancy counter with per-lane entry reservation and metal-alarm lockout timing.
- Drives two 7-segment digits showing occupancy; sits between board switches/sensors and LEDs/HEX displays.

Parameters:
- LANES, 2, number of gates (1..8).
- CNT_W, 8, occupancy counter width.
- CAPACITY, 99, maximum occupancy (≤ 2^CNT_W−1).
- TIMEOUT, 1000, cycles a granted lane waits for giro before abandoning.
- LOCK_CYCLES, 50, cycles of lockout after metais deasserts.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- giro  in  LANES  turnstile rotation sensor per lane (level; rising edge = one passage).
- entrada  in  LANES  entry request per lane.
- saida  in  LANES  exit request per lane.
- metais  in  LANES  metal detected per lane.
- ledVerde  out  LANES  per-lane green lamp.
- ledVermelho  out  LANES  per-lane red lamp.
- ocupacao  out  CNT_W  current occupancy.
- lotado  out  1  ocupacao == CAPACITY.
- alarme  out  1  OR of all lanes in ALARME.
- display0  out  7  low digit, active-low segments gfedcba.
- display1  out  7  high digit, active-low segments gfedcba.

Behaviour:
- Reset (reset_n=0 at an edge): all lanes LIVRE, ocupacao=0, timers 0, giro_prev=0. Outputs: LEDs 0, lotado 0, alarme 0, displays show "00". Reset mid-passage discards the passage with no commit.
- giro edge: giro & ~giro_prev; giro_prev registered every cycle.
- Lane FSM, evaluated per cycle with priority top-down:
  - LIVRE (verde=0, vermelho=0):
    - metais → ALARME.
    - saida → SAIDA; exit wins if entrada and saida are both high.
    - entrada and granted → ENTRADA.
    - entrada not granted → stay LIVRE, vermelho=1 that cycle.
  - ENTRADA (verde=1, vermelho=0):
    - metais → ALARME, no commit.
    - giro edge → commit +1, → LIVRE.
    - timer reaches TIMEOUT−1 → LIVRE, no commit.
  - SAIDA (verde=1, vermelho=1):
    - metais → ALARME.
    - giro edge → commit −1, → LIVRE.
    - timeout → LIVRE.
  - ALARME (verde=0, vermelho=1):
    - Stays while metais=1.
    - metais=0 → BLOQUEIO, timer cleared.
  - BLOQUEIO (verde=0, vermelho=1):
    - metais=1 → ALARME.
    - Timer reaches LOCK_CYCLES−1 → LIVRE.
  - Timers clear on every state change.
- Entry grant: reserved = number of lanes currently in ENTRADA. Same-cycle requesters from LIVRE are granted in ascending lane index while ocupacao + reserved + already_granted_this_cycle < CAPACITY. Occupancy can never exceed CAPACITY.
- Counter update: ocupacao_next = ocupacao + (#entry commits) − (#exit commits), all in the same cycle.
  - Computed at CNT_W+1 bits signed.
  - Clamped to [0, CAPACITY]; an exit from 0 stays 0.
- Latency:
  - Commit happens at the first edge sampling giro=1 with giro_prev=0; ocupacao and lotado are valid after that edge.
  - Displays are registered: one additional cycle.
- giro held high: counts once. giro edge in LIVRE/ALARME/BLOQUEIO: ignored.
- Undefined state encoding → LIVRE.

Optional Feature:
- DISPLAY_DECIMAL_EN defined: displays show ocupacao in decimal (display0 = units, display1 = tens). Values >99 show "--" (segments 0111111 on both digits). Elaboration error if CAPACITY>99.
- Not defined: display0/display1 show low and high hex nibbles of ocupacao[7:0]; values >255 show the low byte.

Decomposition:
- Package catraca_pkg:
  - Lane state enum (LIVRE, ENTRADA, SAIDA, ALARME, BLOQUEIO).
  - Active-low 7-seg constants for 0–F and dash.
  - Function hex_to_seg.
  - Function bin_to_bcd2 (decimal build only).
- Sub-module catraca_lane: one FSM, timer and giro edge detector. Inputs grant and metais; outputs req_entrada, commit_in, commit_out, LEDs and in_alarm. Generated LANES times.
- Top: arbitration, counter and display registers.

Test Plan:
- Reset, then lane0 entrada=1, then giro pulse → ledVerde[0]=1 one cycle after request; ocupacao 0→1; displays "01".
- CAPACITY=2, ocupacao=1, lanes 0 and 1 both entrada same cycle → only lane0 ENTRADA (ledVerde=01); lane1 vermelho=1; after lane0 giro, ocupacao=2 and lotado=1.
- ocupacao=5, lane0 commits entry and lane1 commits exit in the same cycle → ocupacao stays 5; ocupacao=0 with an exit commit → stays 0.
- Lane0 in ENTRADA, metais=1 for 3 cycles then 0 → ALARME, alarme=1; giro ignored; after LOCK_CYCLES back to LIVRE; ocupacao unchanged.
- Lane0 in ENTRADA with no giro for TIMEOUT cycles → returns to LIVRE, reservation released, ocupacao unchanged.
- reset_n=0 during SAIDA with ocupacao=7 → next cycle all outputs zero and displays "00"; DISPLAY_DECIMAL_EN build with ocupacao=42 → display1=0011001 ("4"), display0=0100100 ("2").

Source files
------------

// File: rtl/catraca_pkg.sv
// Shared types and 7-segment helpers for the multi-lane gate controller.
// DISPLAY_DECIMAL_EN adds the binary-to-BCD helper used by the decimal display build.
package catraca_pkg;

    typedef enum logic [2:0] {
        LIVRE    = 3'd0,
        ENTRADA  = 3'd1,
        SAIDA    = 3'd2,
        ALARME   = 3'd3,
        BLOQUEIO = 3'd4
    } lane_state_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b0000011;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

`ifdef DISPLAY_DECIMAL_EN
    // Valid for v <= 99: returns {tens, units}
    function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 8'd10);
        units = 4'(v % 8'd10);
        return {tens, units};
    endfunction
`endif

endpackage

// File: rtl/catraca_lane.sv
// One gate lane: state machine, dwell timer and giro rising-edge detector.
// Entry needs an external grant; commits are single-cycle pulses to the top.
module catraca_lane
    import catraca_pkg::*;
#(
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_CYCLES = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic giro,
    input  logic entrada,
    input  logic saida,
    input  logic metais,
    input  logic grant,
    output logic req_entrada,
    output logic in_entrada,
    output logic commit_in,
    output logic commit_out,
    output logic led_verde,
    output logic led_vermelho,
    output logic in_alarm
);

    localparam int TMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          giro_prev_reg;
    logic          giro_edge;
    logic          timed_state;

    assign giro_edge   = giro & ~giro_prev_reg;
    assign req_entrada = (state_reg == LIVRE) && entrada && !saida && !metais;
    assign in_entrada  = (state_reg == ENTRADA);
    assign in_alarm    = (state_reg == ALARME);
    assign timed_state = (state_reg == ENTRADA) || (state_reg == SAIDA) || (state_reg == BLOQUEIO);

    always_comb begin
        state_next = state_reg;
        commit_in  = 1'b0;
        commit_out = 1'b0;
        case (state_reg)
            LIVRE: begin
                if (metais)                 state_next = ALARME;
                else if (saida)             state_next = SAIDA;
                else if (entrada && grant)  state_next = ENTRADA;
            end
            ENTRADA: begin
                if (metais) begin
                    state_next = ALARME;
                end else if (giro_edge) begin
                    commit_in  = 1'b1;
                    state_next = LIVRE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next = LIVRE;
                end
            end
            SAIDA: begin
                if (metais) begin
                    state_next = ALARME;
                end else if (giro_edge) begin
                    commit_out = 1'b1;
                    state_next = LIVRE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next = LIVRE;
                end
            end
            ALARME: begin
                if (!metais) state_next = BLOQUEIO;
            end
            BLOQUEIO: begin
                if (metais)                                     state_next = ALARME;
                else if (timer_reg == TW'(LOCK_CYCLES - 1))     state_next = LIVRE;
            end
            default: state_next = LIVRE;
        endcase
    end

    // Timer only runs while dwelling in a timed state; any transition restarts it
    always_comb begin
        timer_next = '0;
        if (timed_state && (state_next == state_reg))
            timer_next = timer_reg + 1'b1;
    end

    always_comb begin
        led_verde    = 1'b0;
        led_vermelho = 1'b0;
        case (state_reg)
            LIVRE:    led_vermelho = req_entrada && !grant;
            ENTRADA:  led_verde    = 1'b1;
            SAIDA:    begin led_verde = 1'b1; led_vermelho = 1'b1; end
            ALARME:   led_vermelho = 1'b1;
            BLOQUEIO: led_vermelho = 1'b1;
            default:  led_vermelho = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= LIVRE;
            timer_reg     <= '0;
            giro_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            giro_prev_reg <= giro;
        end
    end

endmodule

// File: rtl/controle_catracas_multi.sv
// Multi-lane gate controller: entry arbitration against capacity, shared occupancy and display.
// DISPLAY_DECIMAL_EN selects a decimal display (units/tens); otherwise two hex nibbles.
module controle_catracas_multi
    import catraca_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int CNT_W       = 8,
    parameter int CAPACITY    = 99,
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_CYCLES = 50
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [LANES-1:0] giro,
    input  logic [LANES-1:0] entrada,
    input  logic [LANES-1:0] saida,
    input  logic [LANES-1:0] metais,
    output logic [LANES-1:0] ledVerde,
    output logic [LANES-1:0] ledVermelho,
    output logic [CNT_W-1:0] ocupacao,
    output logic             lotado,
    output logic             alarme,
    output logic [6:0]       display0,
    output logic [6:0]       display1
);

    logic [LANES-1:0] req_entrada, in_entrada, grant, commit_in, commit_out, in_alarm;
    logic [CNT_W-1:0] ocupacao_reg, ocupacao_next;
    logic [6:0]       display0_reg, display0_next, display1_reg, display1_next;
    logic [7:0]       occ_byte;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            catraca_lane #(
                .TIMEOUT     (TIMEOUT),
                .LOCK_CYCLES (LOCK_CYCLES)
            ) u_lane (
                .clock        (clock),
                .reset_n      (reset_n),
                .giro         (giro[gi]),
                .entrada      (entrada[gi]),
                .saida        (saida[gi]),
                .metais       (metais[gi]),
                .grant        (grant[gi]),
                .req_entrada  (req_entrada[gi]),
                .in_entrada   (in_entrada[gi]),
                .commit_in    (commit_in[gi]),
                .commit_out   (commit_out[gi]),
                .led_verde    (ledVerde[gi]),
                .led_vermelho (ledVermelho[gi]),
                .in_alarm     (in_alarm[gi])
            );
        end

        if (CNT_W >= 8) begin : g_byte_trunc
            assign occ_byte = ocupacao_reg[7:0];
        end else begin : g_byte_ext
            assign occ_byte = {{(8 - CNT_W){1'b0}}, ocupacao_reg};
        end
    endgenerate

    // Free slots = capacity minus people inside minus lanes already holding a reservation
    always_comb begin : p_grant
        int room;
        room  = CAPACITY - int'(ocupacao_reg);
        grant = '0;
        for (int i = 0; i < LANES; i++)
            if (in_entrada[i]) room = room - 1;
        for (int i = 0; i < LANES; i++) begin
            if (req_entrada[i] && (room > 0)) begin
                grant[i] = 1'b1;
                room     = room - 1;
            end
        end
    end

    always_comb begin : p_count
        int total;
        total = int'(ocupacao_reg);
        for (int i = 0; i < LANES; i++) begin
            if (commit_in[i])  total = total + 1;
            if (commit_out[i]) total = total - 1;
        end
        if (total < 0)              ocupacao_next = '0;
        else if (total > CAPACITY)  ocupacao_next = CNT_W'(CAPACITY);
        else                        ocupacao_next = CNT_W'(total);
    end

`ifdef DISPLAY_DECIMAL_EN
    if (CAPACITY > 99) begin : g_cap_err
        $error("controle_catracas_multi: decimal display needs CAPACITY <= 99");
    end

    always_comb begin : p_display
        logic [7:0] bcd;
        bcd           = bin_to_bcd2(occ_byte);
        display0_next = hex_to_seg(bcd[3:0]);
        display1_next = hex_to_seg(bcd[7:4]);
        if (int'(ocupacao_reg) > 99) begin
            display0_next = SEG_DASH;
            display1_next = SEG_DASH;
        end
    end
`else
    always_comb begin : p_display
        display0_next = hex_to_seg(occ_byte[3:0]);
        display1_next = hex_to_seg(occ_byte[7:4]);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ocupacao_reg <= '0;
            display0_reg <= SEG_0;
            display1_reg <= SEG_0;
        end else begin
            ocupacao_reg <= ocupacao_next;
            display0_reg <= display0_next;
            display1_reg <= display1_next;
        end
    end

    assign ocupacao = ocupacao_reg;
    assign lotado   = (ocupacao_reg == CNT_W'(CAPACITY));
    assign alarme   = |in_alarm;
    assign display0 = display0_reg;
    assign display1 = display1_reg;

endmodule

// File: tb/tb_controle_catracas_multi.sv
// Bench for controle_catracas_multi: passage-level occupancy model checked every cycle,
// plus directed scenarios with literal expectations (display checks follow DISPLAY_DECIMAL_EN).
module tb_controle_catracas_multi;

    localparam int LANES       = 2;
    localparam int CNT_W       = 8;
    localparam int CAPACITY    = 45;
    localparam int TIMEOUT     = 20;
    localparam int LOCK_CYCLES = 6;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [LANES-1:0] giro, entrada, saida, metais;
    logic [LANES-1:0] ledVerde, ledVermelho;
    logic [CNT_W-1:0] ocupacao;
    logic             lotado, alarme;
    logic [6:0]       display0, display1;

    always #5 clock = ~clock;

    controle_catracas_multi #(
        .LANES       (LANES),
        .CNT_W       (CNT_W),
        .CAPACITY    (CAPACITY),
        .TIMEOUT     (TIMEOUT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .giro        (giro),
        .entrada     (entrada),
        .saida       (saida),
        .metais      (metais),
        .ledVerde    (ledVerde),
        .ledVermelho (ledVermelho),
        .ocupacao    (ocupacao),
        .lotado      (lotado),
        .alarme      (alarme),
        .display0    (display0),
        .display1    (display1)
    );

    // Model: each lane is an activity with a countdown of remaining cycles
    localparam int IDLE = 0, ENTERING = 1, EXITING = 2, ALARM = 3, LOCKOUT = 4;

    int         m_mode [LANES];
    int         m_left [LANES];
    int         m_occ;
    logic [LANES-1:0] m_prev;
    logic [6:0] m_d0, m_d1;
    bit         m_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [13:0] disp_for(input int v);
`ifdef DISPLAY_DECIMAL_EN
        if (v > 99) return {seg(16), seg(16)};
        return {seg(v / 10), seg(v % 10)};
`else
        int b;
        b = v % 256;
        return {seg(b / 16), seg(b % 16)};
`endif
    endfunction

    function automatic logic [LANES-1:0] wants_entry();
        logic [LANES-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++)
            w[i] = (m_mode[i] == IDLE) && entrada[i] && !saida[i] && !metais[i];
        return w;
    endfunction

    function automatic logic [LANES-1:0] model_grants();
        logic [LANES-1:0] w, g;
        int room;
        w    = wants_entry();
        g    = '0;
        room = CAPACITY - m_occ;
        for (int i = 0; i < LANES; i++)
            if (m_mode[i] == ENTERING) room--;
        for (int i = 0; i < LANES; i++)
            if (w[i] && room > 0) begin
                g[i] = 1'b1;
                room--;
            end
        return g;
    endfunction

    task automatic model_step();
        logic [LANES-1:0] g, rise;
        int delta;
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                m_mode[i] = IDLE;
                m_left[i] = 0;
            end
            m_occ   = 0;
            m_prev  = '0;
            m_d0    = seg(0);
            m_d1    = seg(0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            {m_d1, m_d0} = disp_for(m_occ);
            g     = model_grants();
            rise  = giro & ~m_prev;
            delta = 0;
            for (int i = 0; i < LANES; i++) begin
                case (m_mode[i])
                    IDLE: begin
                        if (metais[i])                  m_mode[i] = ALARM;
                        else if (saida[i])              begin m_mode[i] = EXITING;  m_left[i] = TIMEOUT; end
                        else if (entrada[i] && g[i])    begin m_mode[i] = ENTERING; m_left[i] = TIMEOUT; end
                    end
                    ENTERING, EXITING: begin
                        if (metais[i]) m_mode[i] = ALARM;
                        else if (rise[i]) begin
                            delta     = delta + ((m_mode[i] == ENTERING) ? 1 : -1);
                            m_mode[i] = IDLE;
                        end else begin
                            m_left[i]--;
                            if (m_left[i] == 0) m_mode[i] = IDLE;
                        end
                    end
                    ALARM: if (!metais[i]) begin m_mode[i] = LOCKOUT; m_left[i] = LOCK_CYCLES; end
                    default: begin
                        if (metais[i]) m_mode[i] = ALARM;
                        else begin
                            m_left[i]--;
                            if (m_left[i] == 0) m_mode[i] = IDLE;
                        end
                    end
                endcase
            end
            m_occ = m_occ + delta;
            if (m_occ < 0) m_occ = 0;
            if (m_occ > CAPACITY) m_occ = CAPACITY;
            m_prev = giro;
        end
    endtask

    always @(posedge clock) model_step();

    // Compare process: every cycle, mid-period
    always @(negedge clock) begin
        logic [LANES-1:0] g, w, ev, er;
        int any_alarm;
        if (m_valid) begin
            g = model_grants();
            w = wants_entry();
            any_alarm = 0;
            for (int i = 0; i < LANES; i++) begin
                ev[i] = (m_mode[i] == ENTERING) || (m_mode[i] == EXITING);
                er[i] = (m_mode[i] == EXITING) || (m_mode[i] == ALARM) ||
                        (m_mode[i] == LOCKOUT) || (w[i] && !g[i]);
                if (m_mode[i] == ALARM) any_alarm = 1;
            end
            chk("model_ledVerde",    int'(ledVerde),    int'(ev));
            chk("model_ledVermelho", int'(ledVermelho), int'(er));
            chk("model_ocupacao",    int'(ocupacao),    m_occ);
            chk("model_lotado",      int'(lotado),      (m_occ == CAPACITY) ? 1 : 0);
            chk("model_alarme",      int'(alarme),      any_alarm);
            chk("model_display0",    int'(display0),    int'(m_d0));
            chk("model_display1",    int'(display1),    int'(m_d1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pass_lane(input int lane, input bit is_exit);
        if (is_exit) saida[lane] = 1'b1;
        else         entrada[lane] = 1'b1;
        tick(1);
        saida[lane]   = 1'b0;
        entrada[lane] = 1'b0;
        giro[lane]    = 1'b1;
        tick(1);
        giro[lane]    = 1'b0;
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0;
        giro    = '0;
        entrada = '0;
        saida   = '0;
        metais  = '0;
        tick(3);
        @(negedge clock);
        chk("reset_ocupacao", int'(ocupacao), 0);
        chk("reset_display0", int'(display0), 'b1000000);
        chk("reset_display1", int'(display1), 'b1000000);
        chk("reset_leds",     int'({ledVerde, ledVermelho}), 0);

        // First entry, giro held high for three cycles counts once
        reset_n    = 1'b1;
        entrada[0] = 1'b1;
        tick(1);
        @(negedge clock);
        chk("verde_after_req", int'(ledVerde), 'b01);
        entrada[0] = 1'b0;
        giro[0]    = 1'b1;
        tick(3);
        @(negedge clock);
        chk("first_commit", int'(ocupacao), 1);
        giro[0] = 1'b0;
        tick(1);
        @(negedge clock);
        chk("disp01_d0", int'(display0), 'b1111001);
        chk("disp01_d1", int'(display1), 'b1000000);

        for (int k = 0; k < 43; k++) pass_lane(k % 2, 1'b0);
        @(negedge clock);
        chk("fill_44", int'(ocupacao), 44);

        // One free slot, both lanes ask at once: lane 0 wins
        entrada = 2'b11;
        @(negedge clock);
        chk("contend_red", int'(ledVermelho), 'b10);
        tick(1);
        @(negedge clock);
        chk("contend_green", int'(ledVerde),    'b01);
        chk("reserved_red",  int'(ledVermelho), 'b10);
        entrada = 2'b10;
        giro    = 2'b01;
        tick(1);
        @(negedge clock);
        chk("full_occ",    int'(ocupacao), 45);
        chk("full_lotado", int'(lotado),   1);
        entrada = '0;
        giro    = '0;
        tick(1);

        // Exit, then simultaneous entry and exit leave occupancy unchanged
        pass_lane(1, 1'b1);
        entrada[0] = 1'b1;
        saida[1]   = 1'b1;
        tick(1);
        @(negedge clock);
        chk("inout_green", int'(ledVerde),    'b11);
        chk("inout_red",   int'(ledVermelho), 'b10);
        entrada = '0;
        saida   = '0;
        giro    = 2'b11;
        tick(1);
        @(negedge clock);
        chk("inout_same_cycle", int'(ocupacao), 44);
        giro = '0;
        tick(1);

        pass_lane(0, 1'b1);
        pass_lane(0, 1'b1);
        @(negedge clock);
`ifdef DISPLAY_DECIMAL_EN
        chk("disp42_d1", int'(display1), 'b0011001);
        chk("disp42_d0", int'(display0), 'b0100100);
`else
        chk("disp42_d1", int'(display1), 'b0100100);
        chk("disp42_d0", int'(display0), 'b0001000);
`endif

        for (int k = 0; k < 42; k++) pass_lane(k % 2, 1'b1);
        @(negedge clock);
        chk("drain_zero", int'(ocupacao), 0);
        pass_lane(1, 1'b1);
        @(negedge clock);
        chk("exit_at_zero", int'(ocupacao), 0);

        // Metal during entry: alarm, lockout, giro ignored
        entrada[0] = 1'b1;
        tick(1);
        entrada[0] = 1'b0;
        metais[0]  = 1'b1;
        tick(1);
        @(negedge clock);
        chk("alarm_on", int'(alarme), 1);
        giro[0] = 1'b1;
        tick(1);
        giro[0] = 1'b0;
        tick(1);
        metais[0] = 1'b0;
        tick(1);
        @(negedge clock);
        chk("lock_alarm_off", int'(alarme),      0);
        chk("lock_red",       int'(ledVermelho), 'b01);
        giro[0] = 1'b1;
        tick(1);
        giro[0] = 1'b0;
        tick(LOCK_CYCLES - 2);
        @(negedge clock);
        chk("still_locked", int'(ledVermelho), 'b01);
        tick(1);
        @(negedge clock);
        chk("lock_released",   int'(ledVermelho), 0);
        chk("occ_after_alarm", int'(ocupacao),    0);

        // Entry abandoned after TIMEOUT cycles
        entrada[0] = 1'b1;
        tick(1);
        entrada[0] = 1'b0;
        tick(TIMEOUT - 1);
        @(negedge clock);
        chk("timeout_pending", int'(ledVerde), 'b01);
        tick(1);
        @(negedge clock);
        chk("timeout_release", int'(ledVerde), 0);
        giro[0] = 1'b1;
        tick(1);
        giro[0] = 1'b0;
        tick(1);
        @(negedge clock);
        chk("giro_idle_ignored", int'(ocupacao), 0);

        // Reset in the middle of an exit
        for (int k = 0; k < 7; k++) pass_lane(k % 2, 1'b0);
        saida[0] = 1'b1;
        tick(1);
        saida[0] = 1'b0;
        @(negedge clock);
        chk("pre_reset_occ",  int'(ocupacao),    7);
        chk("pre_reset_leds", int'({ledVerde, ledVermelho}), 'b0101);
        reset_n = 1'b0;
        tick(1);
        @(negedge clock);
        chk("rst_occ",  int'(ocupacao), 0);
        chk("rst_leds", int'({ledVerde, ledVermelho}), 0);
        chk("rst_flags", int'({lotado, alarme}), 0);
        chk("rst_d0",   int'(display0), 'b1000000);
        chk("rst_d1",   int'(display1), 'b1000000);
        reset_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
